// File: rtl/cpu_per_pkg.sv
// Shared types and default widths for the CPU/peripheral handshake link.
package cpu_per_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_REL  = 2'd2
  } c_state_t;

  typedef enum logic {
    P_WAIT = 1'b0,
    P_ACK  = 1'b1
  } p_state_t;

endpackage

// File: rtl/cpu_tx.sv
// CPU-side sender: 4-phase request/release FSM driving an incrementing data word.
//
//  state  | meaning
//  C_IDLE | just out of reset, raises the first request on the next edge
//  C_REQ  | cpu_send high, word held stable until ack seen
//  C_REL  | cpu_send low, waiting for ack to drop before the next word
module cpu_tx
  import cpu_per_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ack_i,
  output logic              send_o,
  output logic [DATA_W-1:0] dados_o
);

  c_state_t          state_q, state_d;
  logic              send_q, send_d;
  logic [DATA_W-1:0] dados_q, dados_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= C_IDLE;
      send_q  <= 1'b0;
      dados_q <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      dados_q <= dados_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  state_d = C_REQ;
      C_REQ:   if (ack_i)  state_d = C_REL;
      C_REL:   if (!ack_i) state_d = C_REQ;
      default: state_d = C_IDLE;
    endcase
  end

  // The word only advances on re-request, so it never moves while send is high.
  always_comb begin
    send_d  = send_q;
    dados_d = dados_q;
    case (state_q)
      C_IDLE: send_d = 1'b1;
      C_REQ:  if (ack_i) send_d = 1'b0;
      C_REL: begin
        if (!ack_i) begin
          send_d  = 1'b1;
          dados_d = dados_q + DATA_W'(1);
        end
      end
      default: begin
        send_d  = 1'b0;
        dados_d = '0;
      end
    endcase
  end

  assign send_o  = send_q;
  assign dados_o = dados_q;

endmodule

// File: rtl/per_rx.sv
// Peripheral-side receiver: acknowledges requests, latches the word and counts transfers.
//
//  state  | meaning
//  P_WAIT | ack low, accepts a request when not busy
//  P_ACK  | ack high, waiting for the sender to drop its request
module per_rx
  import cpu_per_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              busy_i,
  input  logic              send_i,
  input  logic [DATA_W-1:0] dados_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] dados_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  p_state_t          state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] dados_q, dados_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= P_WAIT;
      ack_q   <= 1'b0;
      dados_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dados_q <= dados_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      P_WAIT:  if (send_i && !busy_i) state_d = P_ACK;
      P_ACK:   if (!send_i) state_d = P_WAIT;
      default: state_d = P_WAIT;
    endcase
  end

  // Busy only gates acceptance; once acked the release path ignores it.
  always_comb begin
    ack_d   = ack_q;
    dados_d = dados_q;
    valid_d = 1'b0;
    count_d = count_q;
    case (state_q)
      P_WAIT: begin
        if (send_i && !busy_i) begin
          ack_d   = 1'b1;
          dados_d = dados_i;
          valid_d = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      P_ACK: if (!send_i) ack_d = 1'b0;
      default: ack_d = 1'b0;
    endcase
  end

  assign ack_o   = ack_q;
  assign dados_o = dados_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/cpu_per_link.sv
// Bring-up pair: sender and receiver on one clock with all handshake wires exported.
module cpu_per_link
  import cpu_per_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              cpu_clock,
  input  logic              cpu_reset,
  input  logic              per_busy,
  output logic              cpu_send,
  output logic              per_ack,
  output logic [DATA_W-1:0] cpu_dados,
  output logic [DATA_W-1:0] per_dados,
  output logic              per_valid,
  output logic [CNT_W-1:0]  per_count
);

  cpu_tx #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk_i   (cpu_clock),
    .rst_i   (cpu_reset),
    .ack_i   (per_ack),
    .send_o  (cpu_send),
    .dados_o (cpu_dados)
  );

  per_rx #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rx (
    .clk_i   (cpu_clock),
    .rst_i   (cpu_reset),
    .busy_i  (per_busy),
    .send_i  (cpu_send),
    .dados_i (cpu_dados),
    .ack_o   (per_ack),
    .dados_o (per_dados),
    .valid_o (per_valid),
    .count_o (per_count)
  );

endmodule

// File: tb/tb_cpu_per_link.sv
// Directed bench for cpu_per_link: default widths plus a CNT_W=4 copy for counter wrap.
module tb_cpu_per_link;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy = 1'b0;

  logic       send, ack, valid;
  logic [3:0] dados, pdados;
  logic [7:0] count;

  logic       send2, ack2, valid2;
  logic [3:0] dados2, pdados2;
  logic [3:0] count2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_per_link #(.DATA_W(4), .CNT_W(8)) dut (
    .cpu_clock (clk),
    .cpu_reset (rst),
    .per_busy  (busy),
    .cpu_send  (send),
    .per_ack   (ack),
    .cpu_dados (dados),
    .per_dados (pdados),
    .per_valid (valid),
    .per_count (count)
  );

  cpu_per_link #(.DATA_W(4), .CNT_W(4)) dut4 (
    .cpu_clock (clk),
    .cpu_reset (rst),
    .per_busy  (busy),
    .cpu_send  (send2),
    .per_ack   (ack2),
    .cpu_dados (dados2),
    .per_dados (pdados2),
    .per_valid (valid2),
    .per_count (count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b);
    rst  = 1'b1;
    busy = b;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Protocol watcher, sampled on the falling edge.
  logic p_send = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
  logic [3:0] p_dados = '0;
  int vcnt = 0;

  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      if (p_send && send) chk("dados_stable", 32'(dados), 32'(p_dados));
      if (ack && !p_ack) chk("ack_rise_needs_send", 32'(p_send), 32'd1);
      if (valid) vcnt++;
      if (p_send && !send) begin
        chk("one_valid_per_send", vcnt, 1);
        vcnt = 0;
      end
    end else begin
      vcnt = 0;
    end
    p_send  = send;
    p_ack   = ack;
    p_dados = dados;
    p_rst   = rst;
  end

  int nval;

  initial begin
    // 1: reset values and nominal first transfer
    do_reset(1'b0);
    chk("rst_send", 32'(send), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dados", 32'(dados), 0);
    chk("rst_pdados", 32'(pdados), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_count", 32'(count), 0);
    tick();
    chk("e1_send", 32'(send), 1);
    chk("e1_dados", 32'(dados), 0);
    chk("e1_ack", 32'(ack), 0);
    tick();
    chk("e2_ack", 32'(ack), 1);
    chk("e2_pdados", 32'(pdados), 0);
    chk("e2_valid", 32'(valid), 1);
    chk("e2_count", 32'(count), 1);
    tick();
    chk("e3_send", 32'(send), 0);
    chk("e3_valid", 32'(valid), 0);
    chk("e3_ack", 32'(ack), 1);
    tick();
    chk("e4_ack", 32'(ack), 0);
    chk("e4_send", 32'(send), 0);
    tick();
    chk("e5_send", 32'(send), 1);
    chk("e5_dados", 32'(dados), 1);

    // 2 + 5: free run, sequence, 8-bit count and 4-bit count wrap
    do_reset(1'b0);
    nval = 0;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (valid) begin
        chk("seq_pdados", 32'(pdados), 32'(nval % 16));
        nval++;
      end
      if (e == 58) chk("w4_count_e58", 32'(count2), 15);
      if (e == 61) begin
        chk("dados_e61", 32'(dados), 15);
        chk("send_e61", 32'(send), 1);
      end
      if (e == 62) chk("w4_count_e62", 32'(count2), 0);
      if (e == 65) begin
        chk("dados_wrap_e65", 32'(dados), 0);
        chk("send_e65", 32'(send), 1);
      end
      if (e == 66) begin
        chk("count_e66", 32'(count), 17);
        chk("valids_e66", nval, 17);
        chk("w4_count_e66", 32'(count2), 1);
      end
    end
    chk("count_e70", 32'(count), 18);
    chk("valids_e70", nval, 18);
    chk("pdados_e70", 32'(pdados), 1);

    // 3: busy stall from reset
    do_reset(1'b1);
    repeat (10) tick();
    chk("busy_send", 32'(send), 1);
    chk("busy_dados", 32'(dados), 0);
    chk("busy_ack", 32'(ack), 0);
    chk("busy_count", 32'(count), 0);
    chk("busy_valid", 32'(valid), 0);
    busy = 1'b0;
    tick();
    chk("unbusy_ack", 32'(ack), 1);
    chk("unbusy_pdados", 32'(pdados), 0);
    chk("unbusy_valid", 32'(valid), 1);
    chk("unbusy_count", 32'(count), 1);

    // 4: reset mid-transfer, then restart at word 0
    do_reset(1'b0);
    tick();
    tick();
    chk("mid_pre_send", 32'(send), 1);
    chk("mid_pre_ack", 32'(ack), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_send", 32'(send), 0);
    chk("mid_ack", 32'(ack), 0);
    chk("mid_dados", 32'(dados), 0);
    chk("mid_pdados", 32'(pdados), 0);
    chk("mid_valid", 32'(valid), 0);
    chk("mid_count", 32'(count), 0);
    rst = 1'b0;
    tick();
    chk("restart_send", 32'(send), 1);
    chk("restart_dados", 32'(dados), 0);
    tick();
    chk("restart_ack", 32'(ack), 1);
    chk("restart_pdados", 32'(pdados), 0);
    chk("restart_count", 32'(count), 1);
    repeat (8) tick();
    chk("restart_count2", 32'(count), 3);
    chk("restart_pdados2", 32'(pdados), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
